nios_system_nios2_gen2_0_cpu_ocimem_ctrl: RTL and testbench

System-clock on-chip instrumentation memory (OCIMEM) controller for the Nios II debug path.
- Consumes the decoded debug strobes and jdo payload from the debug-slave sysclk stage.
- Drives MonDReg, monitor_ready and monitor_error back to the debug-slave TCK stage.
- Arbitrates one single-port 32-bit debug RAM between JTAG debug accesses and a CPU-side Avalon-MM slave port.

---
 rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg.sv | 40 ++++
 rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_if.sv | 32 +++
 rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_ram.sv | 25 ++
 rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv | 145 ++++++++++++++
 tb/tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg.sv
// Shared definitions for the OCIMEM controller: jdo field layout, FSM states
// and the debug command record held in the one-deep pending slot.
package nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int JDO_W      = 38;
    localparam int ADDR_LSB   = 10;
    localparam int WDATA_LSB  = 3;
    localparam int CLRERR_BIT = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRD,
        ST_DCAP,
        ST_ARD,
        ST_ACAP
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_A,
        CMD_NA,
        CMD_B
    } cmd_t;

    typedef struct packed {
        cmd_t             kind;
        logic [JDO_W-1:0] jdo;
    } dbg_cmd_t;

    // Coincident strobes resolve as a > no_action_a > b.
    function automatic cmd_t decode_cmd(input logic a, input logic na, input logic b);
        if (a)  return CMD_A;
        if (na) return CMD_NA;
        if (b)  return CMD_B;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_if.sv
// Debug-strobe and Avalon-MM slave signals of the OCIMEM controller.
// master drives requests, slave is the controller.
interface nios_system_nios2_gen2_0_cpu_ocimem_ctrl_if #(
    parameter int ADDR_W = nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg::ADDR_W_DEF
) ();
    logic [nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg::JDO_W-1:0] jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output av_address, av_read, av_write, av_writedata, av_byteenable,
        input  MonDReg, monitor_ready, monitor_error, av_readdata, av_waitrequest
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  av_address, av_read, av_write, av_writedata, av_byteenable,
        output MonDReg, monitor_ready, monitor_error, av_readdata, av_waitrequest
    );
endinterface

// File: rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl_ram.sv
// Single-port synchronous debug RAM, DEPTH x 32, byte-enabled writes,
// one-cycle registered read. Contents are never reset.
module nios_system_nios2_gen2_0_cpu_ocimem_ctrl_ram #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) q <= mem[addr];
    end
endmodule

// File: rtl/nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv
// OCIMEM controller: shares one debug RAM between JTAG debug commands
// (with a one-deep pending slot) and a CPU-side Avalon-MM slave port.
module nios_system_nios2_gen2_0_cpu_ocimem_ctrl
    import nios_system_nios2_gen2_0_cpu_ocimem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic clk,
    input logic reset,
    nios_system_nios2_gen2_0_cpu_ocimem_ctrl_if.slave bus
);
    state_t            state;
    logic [ADDR_W-1:0] mon_a_reg, exec_addr, ram_addr;
    logic [31:0]       mon_d_reg, rd_data, ram_q, ram_wdata;
    logic              ready, error, pend_vld, dbg_oor, av_oor, wr_done, wr_oor;
    logic              exec_vld, has_new, pend_load, drop, av_go_wr, av_go_rd;
    logic              ram_we, ram_re;
    logic [3:0]        ram_be;
    logic [7:0]        jaddr;
    dbg_cmd_t          new_cmd, pend, exec_cmd;
    logic              unused_jdo;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    always_comb begin
        new_cmd.kind = decode_cmd(bus.take_action_ocimem_a, bus.take_no_action_ocimem_a,
                                  bus.take_action_ocimem_b);
        new_cmd.jdo  = bus.jdo;
        has_new      = new_cmd.kind != CMD_NONE;
        exec_cmd     = pend_vld ? pend : new_cmd;
        exec_vld     = (state == ST_IDLE) && (exec_cmd.kind != CMD_NONE);
        jaddr        = exec_cmd.jdo[ADDR_LSB +: 8];
        exec_addr    = (exec_cmd.kind == CMD_A) ? ADDR_W'(jaddr) : mon_a_reg;
        // In IDLE the slot refills only while it is being drained.
        pend_load    = has_new && ((state == ST_IDLE) ? pend_vld : !pend_vld);
        drop         = has_new && (state != ST_IDLE) && pend_vld;
        av_go_wr     = (state == ST_IDLE) && !exec_vld && bus.av_write;
        av_go_rd     = (state == ST_IDLE) && !exec_vld && !bus.av_write && bus.av_read;

        ram_addr  = bus.av_address;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_be    = bus.av_byteenable;
        ram_wdata = bus.av_writedata;
        if (state == ST_DRD) begin
            ram_addr = mon_a_reg;
            ram_re   = 1'b1;
        end else if (exec_vld && exec_cmd.kind == CMD_B) begin
            ram_addr  = mon_a_reg;
            ram_we    = in_range(mon_a_reg);
            ram_be    = 4'hF;
            ram_wdata = exec_cmd.jdo[WDATA_LSB +: 32];
        end else if (av_go_wr) begin
            ram_we = in_range(bus.av_address);
        end else if (av_go_rd) begin
            ram_re = in_range(bus.av_address);
        end
    end

    assign unused_jdo = ^{exec_cmd.jdo[JDO_W-1:CLRERR_BIT+1], exec_cmd.jdo[WDATA_LSB-1:0]};

    always_ff @(posedge clk) begin
        if (pend_load) pend <= new_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mon_a_reg <= '0;
            mon_d_reg <= '0;
            rd_data   <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
            pend_vld  <= 1'b0;
            dbg_oor   <= 1'b0;
            av_oor    <= 1'b0;
            wr_done   <= 1'b0;
            wr_oor    <= 1'b0;
        end else begin
            // Debug writes finish in IDLE; their ack lands one cycle later.
            wr_done <= 1'b0;
            if (wr_done) begin
                ready <= 1'b1;
                if (wr_oor) error <= 1'b1;
            end
            if (pend_load)              pend_vld <= 1'b1;
            else if (state == ST_IDLE)  pend_vld <= 1'b0;
            if (drop) error <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (exec_vld) begin
                        ready <= 1'b0;
                        if (exec_cmd.kind == CMD_A && exec_cmd.jdo[CLRERR_BIT]) error <= 1'b0;
                        if (exec_cmd.kind == CMD_B) begin
                            wr_done   <= 1'b1;
                            wr_oor    <= !in_range(mon_a_reg);
                            mon_a_reg <= mon_a_reg + 1'b1;
                        end else begin
                            mon_a_reg <= exec_addr;
                            dbg_oor   <= !in_range(exec_addr);
                            state     <= in_range(exec_addr) ? ST_DRD : ST_DCAP;
                        end
                    end else if (av_go_rd) begin
                        av_oor <= !in_range(bus.av_address);
                        state  <= ST_ARD;
                    end
                end
                ST_DRD: state <= ST_DCAP;
                ST_DCAP: begin
                    if (dbg_oor) error     <= 1'b1;
                    else         mon_d_reg <= ram_q;
                    ready     <= 1'b1;
                    mon_a_reg <= mon_a_reg + 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ARD: begin
                    rd_data <= av_oor ? 32'h0 : ram_q;
                    state   <= ST_ACAP;
                end
                ST_ACAP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    nios_system_nios2_gen2_0_cpu_ocimem_ctrl_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    assign bus.MonDReg        = mon_d_reg;
    assign bus.monitor_ready  = ready;
    assign bus.monitor_error  = error;
    assign bus.av_readdata    = rd_data;
    assign bus.av_waitrequest = reset | !((state == ST_ACAP) | av_go_wr);
endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Randomized bench for the OCIMEM controller against a word-array model of
// the debug RAM, MonAReg, MonDReg and the sticky error flag.
module tb_nios_system_nios2_gen2_0_cpu_ocimem_ctrl;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nios_system_nios2_gen2_0_cpu_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    nios_system_nios2_gen2_0_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [256];
    logic [7:0]  m_a;
    logic [31:0] m_d;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.av_address = '0;
        bus.av_read = 1'b0;
        bus.av_write = 1'b0;
        bus.av_writedata = '0;
        bus.av_byteenable = '0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic clr);
        logic [37:0] j = '0;
        j[17:10] = addr;
        j[34] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j = '0;
        j[34:3] = data;
        return j;
    endfunction

    // Spec-level effect of one debug read (a or no_action) on the model.
    task automatic model_read(input logic is_a, input logic [7:0] addr, input logic clr,
                              output int lat);
        logic [7:0] a = is_a ? addr : m_a;
        if (is_a && clr) m_err = 1'b0;
        if (a >= DEPTH) m_err = 1'b1;
        else            m_d = mem[a];
        m_a = a + 8'd1;
        lat = (a >= DEPTH) ? 2 : 3;
    endtask

    task automatic wait_ready(input int exp_lat);
        int lat = 1;
        while (!bus.monitor_ready && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dbg_latency", lat, exp_lat);
    endtask

    // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b
    task automatic dbg_op(input int kind, input logic [7:0] addr, input logic clr,
                          input logic [31:0] data);
        int lat;
        if (kind == 0)      bus.jdo = jdo_a(addr, clr);
        else if (kind == 2) bus.jdo = jdo_b(data);
        else                bus.jdo = {6'($urandom), $urandom()};
        bus.take_action_ocimem_a    = (kind == 0);
        bus.take_no_action_ocimem_a = (kind == 1);
        bus.take_action_ocimem_b    = (kind == 2);
        @(posedge clk); #1;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        if (kind == 2) begin
            if (m_a >= DEPTH) m_err = 1'b1;
            else              mem[m_a] = data;
            m_a = m_a + 8'd1;
            lat = 2;
        end else begin
            model_read(kind == 0, addr, clr, lat);
        end
        wait_ready(lat);
        check("dbg_mondreg", bus.MonDReg, m_d);
        check("dbg_error", {31'd0, bus.monitor_error}, {31'd0, m_err});
    endtask

    task automatic av_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        int stalls = 0;
        bus.av_address = addr; bus.av_writedata = data; bus.av_byteenable = be; bus.av_write = 1'b1;
        @(negedge clk);
        while (bus.av_waitrequest && stalls < 10) begin stalls++; @(negedge clk); end
        @(posedge clk); #1;
        bus.av_write = 1'b0;
        check("av_wr_stall", stalls, 0);
        if (addr < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) mem[addr][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic av_read(input logic [7:0] addr);
        int stalls = 0;
        bus.av_address = addr; bus.av_read = 1'b1;
        @(negedge clk);
        while (bus.av_waitrequest && stalls < 10) begin stalls++; @(negedge clk); end
        check("av_rd_stall", stalls, 2);
        check("av_rd_data", bus.av_readdata, (addr < DEPTH) ? mem[addr] : 32'h0);
        @(posedge clk); #1;
        bus.av_read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  base;
        logic [31:0] d;
        drive_idle();
        reset = 1'b1;
        bus.av_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mondreg", bus.MonDReg, 32'h0);
        check("rst_ready", {31'd0, bus.monitor_ready}, 32'd0);
        check("rst_error", {31'd0, bus.monitor_error}, 32'd0);
        check("rst_readdata", bus.av_readdata, 32'h0);
        check("rst_waitreq", {31'd0, bus.av_waitrequest}, 32'd1);
        bus.av_write = 1'b0;
        reset = 1'b0;
        m_a = '0; m_d = '0; m_err = 1'b0;
        @(posedge clk); #1;
        check("idle_waitreq", {31'd0, bus.av_waitrequest}, 32'd1);

        for (int a = 0; a < DEPTH; a++) av_write(8'(a), $urandom(), 4'hF);

        // Write then read back through the auto-incrementing debug address.
        dbg_op(0, 8'h10, 1'b0, '0);
        dbg_op(2, '0, 1'b0, 32'hDEADBEEF);
        dbg_op(0, 8'h11, 1'b0, '0);
        check("wr_rd_value", bus.MonDReg, 32'hDEADBEEF);
        dbg_op(1, '0, 1'b0, '0);

        // Streaming reads.
        av_write(8'h20, 32'd1, 4'hF);
        av_write(8'h21, 32'd2, 4'hF);
        av_write(8'h22, 32'd3, 4'hF);
        dbg_op(0, 8'h20, 1'b0, '0);
        check("stream_0", bus.MonDReg, 32'd1);
        dbg_op(1, '0, 1'b0, '0);
        check("stream_1", bus.MonDReg, 32'd2);
        dbg_op(1, '0, 1'b0, '0);
        check("stream_2", bus.MonDReg, 32'd3);

        // Out of range at the top of the address space, then wrap and clear.
        dbg_op(0, 8'hFF, 1'b0, '0);
        check("oor_error", {31'd0, bus.monitor_error}, 32'd1);
        check("oor_mondreg_kept", bus.MonDReg, 32'd3);
        dbg_op(1, '0, 1'b0, '0);
        dbg_op(0, 8'h00, 1'b1, '0);
        check("clr_error", {31'd0, bus.monitor_error}, 32'd0);

        // Debug write beats a simultaneous Avalon read of the same word.
        dbg_op(0, 8'h04, 1'b0, '0);
        d = $urandom();
        bus.av_address = 8'h05; bus.av_read = 1'b1;
        bus.jdo = jdo_b(d); bus.take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        bus.take_action_ocimem_b = 1'b0;
        mem[5] = d; m_a = 8'h06;
        begin
            int stalls = 0;
            @(negedge clk);
            while (bus.av_waitrequest && stalls < 10) begin stalls++; @(negedge clk); end
            check("arb_stall", stalls, 2);
            check("arb_rdata", bus.av_readdata, d);
        end
        @(posedge clk); #1;
        bus.av_read = 1'b0;
        check("arb_dbg_ready", {31'd0, bus.monitor_ready}, 32'd1);
        dbg_op(1, '0, 1'b0, '0);

        // Three back-to-back strobes: second waits in the slot, third is dropped.
        base = 8'($urandom_range(0, DEPTH - 4));
        bus.jdo = jdo_a(base, 1'b0); bus.take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        bus.take_action_ocimem_a = 1'b0; bus.take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.take_no_action_ocimem_a = 1'b0;
        m_d = mem[base + 8'd1]; m_a = base + 8'd2; m_err = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("ovf_mondreg", bus.MonDReg, m_d);
        check("ovf_error", {31'd0, bus.monitor_error}, 32'd1);
        check("ovf_ready", {31'd0, bus.monitor_ready}, 32'd1);
        dbg_op(1, '0, 1'b0, '0);
        dbg_op(0, 8'h30, 1'b1, '0);

        // Reset while the RAM address is being presented for a debug read.
        bus.jdo = jdo_a(8'h21, 1'b0); bus.take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        bus.take_action_ocimem_a = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_mondreg", bus.MonDReg, 32'h0);
        check("mid_rst_ready", {31'd0, bus.monitor_ready}, 32'd0);
        check("mid_rst_waitreq", {31'd0, bus.av_waitrequest}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        m_a = '0; m_d = '0; m_err = 1'b0;
        dbg_op(1, '0, 1'b0, '0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: dbg_op(0, 8'($urandom), 1'($urandom_range(0, 1)), '0);
                1: dbg_op(1, '0, 1'b0, '0);
                2: dbg_op(2, '0, 1'b0, $urandom());
                3: av_write(8'($urandom), $urandom(), 4'($urandom));
                default: av_read(8'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
